branch_pc_sequencer: RTL and testbench
======================================

Name: branch_pc_sequencer

Overview:
- Consumes the conditional flip-flop's CON output and sequences the program counter for each issued instruction.
- Non-branch: PC advances by 1. Branch: the block strobes the CFF latch, waits for it to settle, then selects the taken target (PC+1+sign-extended IR[18:0]) or the fall-through PC+1.
- Sits between the decode/issue stage (upstream) and fetch (downstream), with a valid/ready handshake on each side.

Parameters:
- PC_W, 32, program counter width.
- RESET_PC, 0, PC value loaded on reset.
- SETTLE_CYCLES, 1, wait cycles after the CFF strobe before CON is sampled (range 1..15).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  decode presents an instruction.
- issue_ready  output  1  block accepts an instruction (high only in IDLE).
- is_branch  input  1  instruction is brzr/brnz/brpl/brmi; sampled on issue handshake.
- IR  input  32  instruction register; IR[18:0] is the branch displacement, captured on issue handshake.
- con_strobe  output  1  one-cycle pulse driving the CFF IN (latch) pin.
- con_q  input  1  CFF OUT; sampled in RESOLVE only.
- pc  output  PC_W  current program counter.
- pc_valid  output  1  new PC available to fetch.
- pc_ready  input  1  fetch accepts the new PC.
- taken  output  1  last resolved branch was taken; valid while pc_valid.

Behaviour:
- Reset (async, Reset_n low): state=IDLE, pc=RESET_PC, pc_valid=0, con_strobe=0, taken=0, settle counter=0, captured displacement=0. On release, the first issue_ready is in the same cycle.
- States: IDLE, STROBE, SETTLE, RESOLVE, DONE.
- IDLE:
  - issue_ready=1.
  - On issue_valid&issue_ready, capture is_branch and IR[18:0].
  - Branch → STROBE.
  - Non-branch → pc<=pc+1, taken<=0 → DONE.
- STROBE: con_strobe=1 for exactly this cycle; load settle counter with SETTLE_CYCLES → SETTLE.
- SETTLE: decrement counter each cycle; when it reaches 0 → RESOLVE.
- RESOLVE:
  - con_q=1: pc<=pc+1+sext(disp19), taken<=1.
  - con_q=0: pc<=pc+1, taken<=0.
  - → DONE.
- DONE:
  - pc_valid=1, with pc and taken stable.
  - On pc_ready → IDLE, pc_valid deasserts next cycle.
  - pc_ready low: hold indefinitely.
- Latency (issue handshake to pc_valid):
  - Non-branch: 1 cycle.
  - Branch: 3+SETTLE_CYCLES cycles (4 at default).
- Arithmetic: modulo 2^PC_W, wraps silently (max+1 → 0). Displacement is sign-extended from bit 18; negative displacements wrap below 0.
- issue_valid outside IDLE is ignored (issue_ready=0). IR and is_branch changing after the handshake have no effect.
- con_q is ignored outside RESOLVE. Glitches during SETTLE have no effect.
- pc_ready while pc_valid=0 is ignored.
- Reset mid-operation (any state) aborts immediately to reset values. A pending con_strobe pulse is cut.
- Outputs are registered; no combinational path from inputs to outputs except issue_ready (decoded from state only).

Optional Feature:
- Macro: BRANCH_PC_STATS_EN.
- Defined:
  - Adds outputs stat_taken[15:0] and stat_not_taken[15:0].
  - Each increments once per RESOLVE cycle according to the con_q outcome.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package branch_pkg:
  - State enum (IDLE=0, STROBE=1, SETTLE=2, RESOLVE=3, DONE=4, 3-bit encoding).
  - DISP_W=19, DISP_MSB=18.
  - Function sext_disp(19→PC_W).
- One natural sub-module: branch_target_adder (pc, disp19, take → next_pc), purely combinational. FSM and counters stay in the top.

Test Plan:
- Reset: hold Reset_n=0 with RESET_PC=0x100 → pc=0x100, pc_valid=0, issue_ready=1. Release → first issue is accepted in the first cycle.
- Non-branch issue at pc=0x100, pc_ready=1 → pc_valid after 1 cycle, pc=0x101, taken=0, con_strobe never pulses.
- Branch taken: pc=0x200, IR[18:0]=0x00010, con_q=1 → single con_strobe pulse, pc_valid 4 cycles after issue, pc=0x211, taken=1.
- Branch not taken with negative displacement: IR[18:0]=0x7FFF0, con_q=0 → pc=0x201. Repeat with con_q=1 → pc=0x1F1.
- Backpressure plus ignored inputs:
  - pc_ready=0 for 5 cycles in DONE → pc/taken stable, issue_ready=0.
  - issue_valid pulses in this window are ignored.
  - pc_ready=1 → IDLE next cycle.
- Wrap and reset mid-op:
  - pc=0xFFFFFFFF, non-branch → pc=0.
  - Assert Reset_n=0 during SETTLE → immediate pc=RESET_PC, no pc_valid.
  - With BRANCH_PC_STATS_EN, after 3 taken and 2 not-taken → stat_taken=3, stat_not_taken=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch PC sequencer.
//   state_e   : sequencer FSM state encoding (3-bit).
//   DISP_W    : width of the branch displacement field carried in IR.
//   DISP_MSB  : sign bit of the displacement field.
//   MAX_PC_W  : widest PC the helpers support; sext_disp returns this width.
//   sext_disp : sign-extends a 19-bit displacement to MAX_PC_W bits.
package branch_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StStrobe  = 3'd1,
      StSettle  = 3'd2,
      StResolve = 3'd3,
      StDone    = 3'd4
   } state_e;

   localparam int unsigned DISP_W   = 19;
   localparam int unsigned DISP_MSB = 18;
   localparam int unsigned MAX_PC_W = 64;

   // Callers truncate to their own PC width.
   function automatic logic [MAX_PC_W-1:0] sext_disp(input logic [DISP_W-1:0] disp);
      return {{(MAX_PC_W-DISP_W){disp[DISP_MSB]}}, disp};
   endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Next-PC adder for the branch PC sequencer (purely combinational).
//   pc      : current program counter
//   disp    : 19-bit branch displacement
//   take    : add the sign-extended displacement on top of the +1 step
//   next_pc : pc + 1 (+ sext(disp) when take), modulo 2^PC_W
module branch_target_adder
   import branch_pkg::*;
#(
   parameter int unsigned PC_W = 32
) (
   input  logic [PC_W-1:0]   pc,
   input  logic [DISP_W-1:0] disp,
   input  logic              take,
   output logic [PC_W-1:0]   next_pc
);

   // Only the low PC_W bits of the extended displacement matter.
   logic [MAX_PC_W-1:0] sext_unused_upper;
   logic [PC_W-1:0]     offset;

   assign sext_unused_upper = sext_disp(disp);
   assign offset            = take ? sext_unused_upper[PC_W-1:0] : '0;
   assign next_pc           = pc + PC_W'(1) + offset;

endmodule

// File: rtl/branch_pc_sequencer.sv
// Branch PC sequencer: advances the PC for each issued instruction. Branches strobe the
// conditional flip-flop, wait SETTLE_CYCLES, then sample con_q to pick target or fall-through.
//   Clk, Reset_n          : clock (rising edge), asynchronous active-low reset
//   issue_valid/ready     : upstream handshake; is_branch and IR[18:0] captured on it
//   con_strobe            : one-cycle latch pulse to the CFF
//   con_q                 : CFF output, sampled only in RESOLVE
//   pc, taken             : new PC and branch outcome, stable while pc_valid
//   pc_valid/pc_ready     : downstream handshake
// Optional: define BRANCH_PC_STATS_EN to add saturating stat_taken/stat_not_taken counters.
module branch_pc_sequencer
   import branch_pkg::*;
#(
   parameter int unsigned    PC_W          = 32,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter int unsigned    SETTLE_CYCLES = 1
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic            is_branch,
   input  logic [31:0]     IR,
   output logic            con_strobe,
   input  logic            con_q,
   output logic [PC_W-1:0] pc,
   output logic            pc_valid,
   input  logic            pc_ready,
   output logic            taken
`ifdef BRANCH_PC_STATS_EN
   ,
   output logic [15:0]     stat_taken,
   output logic [15:0]     stat_not_taken
`endif
);

   localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);

   state_e            state;
   logic [3:0]        settle_cnt;
   logic [DISP_W-1:0] disp;
   logic              adder_take;
   logic [PC_W-1:0]   next_pc;
   logic              unused_ir;

   assign unused_ir   = ^IR[31:DISP_W];
   assign issue_ready = (state == StIdle);
   // Non-branch issue shares the adder with take forced low (pc + 1).
   assign adder_take  = (state == StResolve) && con_q;

   branch_target_adder #(
      .PC_W(PC_W)
   ) u_adder (
      .pc     (pc),
      .disp   (disp),
      .take   (adder_take),
      .next_pc(next_pc)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= StIdle;
         pc         <= RESET_PC;
         pc_valid   <= 1'b0;
         con_strobe <= 1'b0;
         taken      <= 1'b0;
         settle_cnt <= '0;
         disp       <= '0;
      end else begin
         con_strobe <= 1'b0;
         unique case (state)
            StIdle: begin
               if (issue_valid) begin
                  disp <= IR[DISP_MSB:0];
                  if (is_branch) begin
                     con_strobe <= 1'b1;
                     state      <= StStrobe;
                  end else begin
                     pc       <= next_pc;
                     taken    <= 1'b0;
                     pc_valid <= 1'b1;
                     state    <= StDone;
                  end
               end
            end
            StStrobe: begin
               settle_cnt <= SettleLoad;
               state      <= StSettle;
            end
            StSettle: begin
               settle_cnt <= settle_cnt - 4'd1;
               if (settle_cnt <= 4'd1) state <= StResolve;
            end
            StResolve: begin
               pc       <= next_pc;
               taken    <= con_q;
               pc_valid <= 1'b1;
               state    <= StDone;
            end
            StDone: begin
               if (pc_ready) begin
                  pc_valid <= 1'b0;
                  state    <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef BRANCH_PC_STATS_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         stat_taken     <= '0;
         stat_not_taken <= '0;
      end else if (state == StResolve) begin
         if (con_q && stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'd1;
         if (!con_q && stat_not_taken != 16'hFFFF) stat_not_taken <= stat_not_taken + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer (RESET_PC = 0x100, SETTLE_CYCLES = 1).
module tb_branch_pc_sequencer;

   localparam int SETTLE = 1;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic        is_branch = 1'b0;
   logic [31:0] IR = '0;
   logic        con_strobe;
   logic        con_q = 1'b0;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pc_ready = 1'b1;
   logic        taken;
`ifdef BRANCH_PC_STATS_EN
   logic [15:0] stat_taken;
   logic [15:0] stat_not_taken;
`endif

   branch_pc_sequencer #(
      .PC_W         (32),
      .RESET_PC     (32'h100),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .issue_valid(issue_valid),
      .issue_ready(issue_ready),
      .is_branch  (is_branch),
      .IR         (IR),
      .con_strobe (con_strobe),
      .con_q      (con_q),
      .pc         (pc),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .taken      (taken)
`ifdef BRANCH_PC_STATS_EN
      ,
      .stat_taken    (stat_taken),
      .stat_not_taken(stat_not_taken)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        br;
      logic [18:0] disp;
      logic        con;
      logic [31:0] exp_pc;
      logic        exp_taken;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      int          lat;
      int          strobes;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   n_taken = 0;
   int   n_not_taken = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one instruction at the current negedge and follows it to pc_valid.
   // con_q is driven inverted on every edge except the RESOLVE edge.
   task automatic do_issue(input logic br, input logic [18:0] d, input logic c,
                           input logic [31:0] epc, input logic et);
      int   k;
      int   strobes;
      bit   got;
      exp_t e;
      k = 0;
      while (!issue_ready && k < 20) begin
         @(negedge Clk);
         k++;
      end
      check("issue_ready_before_issue", 32'(issue_ready), 32'd1);
      issue_valid = 1'b1;
      is_branch   = br;
      IR          = {13'h1555, d};
      con_q       = ~c;
      sb.push_back('{pc: epc, taken: et, lat: (br ? 3 + SETTLE : 1), strobes: (br ? 1 : 0)});
      @(negedge Clk);
      issue_valid = 1'b0;
      is_branch   = ~br;
      IR          = $urandom;
      strobes     = 0;
      got         = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         if (con_strobe) strobes++;
         if (pc_valid) begin
            got = 1;
            e   = sb.pop_front();
            check("pc", pc, e.pc);
            check("taken", 32'(taken), 32'(e.taken));
            check("latency", 32'(i), 32'(e.lat));
            check("strobe_count", 32'(strobes), 32'(e.strobes));
         end else begin
            con_q = (i == 2 + SETTLE) ? c : ~c;
            @(negedge Clk);
         end
      end
      if (!got) begin
         check("pc_valid_timeout", 32'd0, 32'd1);
         void'(sb.pop_front());
      end
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b0, 19'h00000, 1'b0, 32'h0000_0101, 1'b0};
      vecs[1] = '{1'b1, 19'h000FE, 1'b1, 32'h0000_0200, 1'b1};
      vecs[2] = '{1'b1, 19'h00010, 1'b1, 32'h0000_0211, 1'b1};
      vecs[3] = '{1'b1, 19'h7FFEE, 1'b1, 32'h0000_0200, 1'b1};
      vecs[4] = '{1'b1, 19'h7FFF0, 1'b0, 32'h0000_0201, 1'b0};
      vecs[5] = '{1'b1, 19'h7FFFE, 1'b1, 32'h0000_0200, 1'b1};
      vecs[6] = '{1'b1, 19'h7FFF0, 1'b1, 32'h0000_01F1, 1'b1};
      vecs[7] = '{1'b1, 19'h7FE0D, 1'b1, 32'hFFFF_FFFF, 1'b1};
      vecs[8] = '{1'b0, 19'h12345, 1'b1, 32'h0000_0000, 1'b0};
      vecs[9] = '{1'b1, 19'h00005, 1'b0, 32'h0000_0001, 1'b0};

      // Reset state
      repeat (3) @(negedge Clk);
      check("reset_pc", pc, 32'h100);
      check("reset_pc_valid", 32'(pc_valid), 32'd0);
      check("reset_issue_ready", 32'(issue_ready), 32'd1);
      check("reset_con_strobe", 32'(con_strobe), 32'd0);
      check("reset_taken", 32'(taken), 32'd0);
      Reset_n = 1'b1;

      // Table: first issue lands in the first cycle after release
      for (int v = 0; v < 10; v++) begin
         do_issue(vecs[v].br, vecs[v].disp, vecs[v].con, vecs[v].exp_pc, vecs[v].exp_taken);
         if (vecs[v].br) begin
            if (vecs[v].con) n_taken++;
            else n_not_taken++;
         end
         @(negedge Clk);
         check("pc_valid_drop", 32'(pc_valid), 32'd0);
         check("idle_issue_ready", 32'(issue_ready), 32'd1);
      end

      // Backpressure: hold DONE for 5 cycles while issue_valid pulses are ignored
      pc_ready = 1'b0;
      do_issue(1'b0, 19'h0, 1'b0, 32'h2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         issue_valid = i[0] ? 1'b0 : 1'b1;
         is_branch   = 1'b1;
         @(negedge Clk);
         check("bp_pc_valid", 32'(pc_valid), 32'd1);
         check("bp_pc", pc, 32'h2);
         check("bp_taken", 32'(taken), 32'd0);
         check("bp_issue_ready", 32'(issue_ready), 32'd0);
      end
      issue_valid = 1'b0;
      pc_ready    = 1'b1;
      @(negedge Clk);
      check("bp_release_pc_valid", 32'(pc_valid), 32'd0);
      check("bp_release_issue_ready", 32'(issue_ready), 32'd1);
      @(negedge Clk);
      check("bp_no_late_issue", 32'(issue_ready), 32'd1);
      check("bp_no_strobe", 32'(con_strobe), 32'd0);
      check("bp_pc_hold", pc, 32'h2);

`ifdef BRANCH_PC_STATS_EN
      check("stat_taken", 32'(stat_taken), 32'(n_taken));
      check("stat_not_taken", 32'(stat_not_taken), 32'(n_not_taken));
`endif

      // Reset during STROBE cuts the pulse
      issue_valid = 1'b1;
      is_branch   = 1'b1;
      IR          = 32'h0000_0010;
      @(negedge Clk);
      issue_valid = 1'b0;
      check("strobe_before_reset", 32'(con_strobe), 32'd1);
      Reset_n = 1'b0;
      #1;
      check("strobe_cut", 32'(con_strobe), 32'd0);
      check("rst_strobe_pc", pc, 32'h100);
      check("rst_strobe_ready", 32'(issue_ready), 32'd1);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Reset during SETTLE
      issue_valid = 1'b1;
      @(negedge Clk);
      issue_valid = 1'b0;
      @(negedge Clk);
      check("settle_no_strobe", 32'(con_strobe), 32'd0);
      Reset_n = 1'b0;
      #1;
      check("rst_settle_pc", pc, 32'h100);
      check("rst_settle_pc_valid", 32'(pc_valid), 32'd0);
      check("rst_settle_ready", 32'(issue_ready), 32'd1);
`ifdef BRANCH_PC_STATS_EN
      check("rst_stat_taken", 32'(stat_taken), 32'd0);
      check("rst_stat_not_taken", 32'(stat_not_taken), 32'd0);
`endif
      repeat (3) @(negedge Clk);
      check("rst_hold_pc_valid", 32'(pc_valid), 32'd0);
      Reset_n = 1'b1;

      // Issue straight out of reset
      do_issue(1'b0, 19'h0, 1'b0, 32'h101, 1'b0);
      @(negedge Clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
